stream_packet_feeder: RTL and testbench

- Upstream neighbour of the s2mem AXI4-Stream writer; drives its data/data_valid/data_last inputs and consumes its ready output.
- Accepts a packet command carrying a word count and buffers source words in a small FWFT FIFO.
- Emits exactly cmd_len words with data_last on the final word, honouring writer backpressure.
- Pulses done when the final word has been handed off.

---
 rtl/stream_packet_feeder.sv | 175 +++++++++++++++++
 tb/tb_stream_packet_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_feeder.sv
// Packet feeder in front of the s2mem writer: buffers source words in a small FWFT FIFO.
// It emits exactly cmd_len words, with last on the final word, and holds its output while the writer stalls.

module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push_en;
  logic                  pop_en;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  // The head entry is always visible, so a stored word shows on the output the cycle after it is written.
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module stream_packet_feeder #(
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_LEN_WIDTH       = 16,
  parameter int C_FIFO_DEPTH_LOG2 = 3
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  input  logic [C_LEN_WIDTH-1:0]  cmd_len,
  output logic                    cmd_ready,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [C_DATA_WIDTH-1:0] data,
  output logic                    data_valid,
  output logic                    data_last,
  input  logic                    ready,
  output logic                    busy,
  output logic                    done
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [C_LEN_WIDTH-1:0] len_reg;
  logic [C_LEN_WIDTH-1:0] len_m1;
  logic [C_LEN_WIDTH-1:0] in_cnt;
  logic [C_LEN_WIDTH-1:0] out_cnt;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   cmd_fire;
  logic                   in_fire;
  logic                   out_fire;

  assign len_m1     = len_reg - 1'b1;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign in_fire    = in_valid && in_ready;
  assign data_valid = !fifo_empty;
  assign out_fire   = data_valid && ready;
  assign data_last  = data_valid && (out_cnt == len_m1);

  sync_fifo #(
    .WIDTH      (C_DATA_WIDTH),
    .DEPTH_LOG2 (C_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (ACLK),
    .rst      (ARESET),
    .push     (in_fire),
    .push_dat (in_data),
    .pop      (out_fire),
    .pop_dat  (data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Stop accepting once the whole packet is in; a full FIFO blocks even if it drains this cycle.
        in_ready = (in_cnt != len_reg) && !fifo_full;
        if (out_fire && (out_cnt == len_m1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      len_reg <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (cmd_fire) begin
      len_reg <= cmd_len;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_fire) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (out_fire) begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_packet_feeder.sv
// Directed bench for stream_packet_feeder: inputs change and outputs are checked on the falling edge.
module tb_stream_packet_feeder;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid;
  logic [15:0] cmd_len;
  logic        cmd_ready;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic        data_valid;
  logic        data_last;
  logic        ready;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  stream_packet_feeder dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .data_valid (data_valid),
    .data_last  (data_last),
    .ready      (ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_len = '0;
    in_data = '0; in_valid = 1'b0; ready = 1'b0;
    tick(); tick();
    ARESET = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_last", data_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Packet of 4, streaming with no stalls.
    cmd_valid = 1'b1; cmd_len = 16'd4;
    tick();
    cmd_valid = 1'b0;
    check("p4_busy", busy, 1);
    check("p4_cmd_ready", cmd_ready, 0);
    check("p4_in_ready", in_ready, 1);
    check("p4_dv_before", data_valid, 0);
    in_valid = 1'b1; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'hA0 + k;
      tick();
      check($sformatf("p4_dv%0d", k), data_valid, 1);
      check($sformatf("p4_data%0d", k), data, 32'hA0 + k);
      check($sformatf("p4_last%0d", k), data_last, (k == 3));
      check($sformatf("p4_done%0d", k), done, 0);
    end
    check("p4_in_ready_end", in_ready, 0);
    in_valid = 1'b0;
    tick();
    check("p4_done", done, 1);
    check("p4_busy_done", busy, 0);
    check("p4_dv_done", data_valid, 0);
    check("p4_cmd_ready_done", cmd_ready, 0);
    tick();
    check("p4_done_clr", done, 0);
    check("p4_cmd_ready_idle", cmd_ready, 1);

    // Packet of 12 with the writer stalled: FIFO fills at 8 and the head word holds.
    cmd_valid = 1'b1; cmd_len = 16'd12; ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("p12_stall_in_ready%0d", i), in_ready, (i < 8));
      if (i >= 1) begin
        check($sformatf("p12_stall_dv%0d", i), data_valid, 1);
        check($sformatf("p12_stall_data%0d", i), data, 32'hB0);
        check($sformatf("p12_stall_last%0d", i), data_last, 0);
      end
      in_data = 32'hB0 + ((i < 8) ? i : 8);
      tick();
    end
    ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      check($sformatf("p12_dv%0d", j), data_valid, 1);
      check($sformatf("p12_data%0d", j), data, 32'hB0 + j);
      check($sformatf("p12_last%0d", j), data_last, (j == 11));
      check($sformatf("p12_in_ready%0d", j), in_ready, (j >= 1 && j <= 4));
      if (j >= 1 && j <= 4) in_data = 32'hB8 + (j - 1);
      if (j >= 5) in_valid = 1'b0;
      tick();
    end
    check("p12_done", done, 1);
    check("p12_dv_done", data_valid, 0);
    tick();

    // Packet of 3 while upstream keeps offering more words.
    cmd_valid = 1'b1; cmd_len = 16'd3;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b1; ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("p3_in_ready%0d", k), in_ready, (k < 3));
      check($sformatf("p3_done%0d", k), done, (k == 4));
      if (k >= 1 && k <= 3) begin
        check($sformatf("p3_data%0d", k), data, 32'hC0 + k - 1);
        check($sformatf("p3_last%0d", k), data_last, (k == 3));
      end
      if (k >= 4) check($sformatf("p3_dv%0d", k), data_valid, 0);
      in_data = 32'hC0 + ((k < 3) ? k : 3);
      tick();
    end
    in_valid = 1'b0;

    // Empty packet.
    cmd_valid = 1'b1; cmd_len = 16'd0; in_valid = 1'b1; in_data = 32'hEE;
    tick();
    cmd_valid = 1'b0;
    check("p0_done", done, 1);
    check("p0_dv", data_valid, 0);
    check("p0_in_ready", in_ready, 0);
    check("p0_busy", busy, 0);
    check("p0_cmd_ready", cmd_ready, 0);
    tick();
    check("p0_done_clr", done, 0);
    check("p0_cmd_ready_idle", cmd_ready, 1);
    check("p0_in_ready_idle", in_ready, 0);
    check("p0_dv_idle", data_valid, 0);
    in_valid = 1'b0;

    // Single-word packet.
    cmd_valid = 1'b1; cmd_len = 16'd1;
    tick();
    cmd_valid = 1'b0;
    check("p1_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'hD0;
    tick();
    in_valid = 1'b0;
    check("p1_dv", data_valid, 1);
    check("p1_data", data, 32'hD0);
    check("p1_last", data_last, 1);
    check("p1_in_ready_full", in_ready, 0);
    tick();
    check("p1_done", done, 1);
    check("p1_dv_done", data_valid, 0);
    tick();

    // Reset mid-packet, then a clean packet of 2.
    ready = 1'b0;
    cmd_valid = 1'b1; cmd_len = 16'd6;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'hE0 + k;
      tick();
    end
    in_valid = 1'b0; ready = 1'b1;
    tick(); tick(); tick();
    check("p6_dv_pre", data_valid, 1);
    check("p6_data_pre", data, 32'hE3);
    check("p6_busy_pre", busy, 1);
    ARESET = 1'b1; ready = 1'b0;
    tick();
    ARESET = 1'b0;
    check("p6_rst_dv", data_valid, 0);
    check("p6_rst_busy", busy, 0);
    check("p6_rst_cmd_ready", cmd_ready, 1);
    check("p6_rst_done", done, 0);
    check("p6_rst_in_ready", in_ready, 0);
    tick();
    check("p6_rst_done_next", done, 0);
    check("p6_rst_dv_next", data_valid, 0);

    cmd_valid = 1'b1; cmd_len = 16'd2;
    tick();
    cmd_valid = 1'b0;
    ready = 1'b1; in_valid = 1'b1; in_data = 32'hF0;
    check("p2_in_ready", in_ready, 1);
    check("p2_dv_empty", data_valid, 0);
    tick();
    check("p2_data0", data, 32'hF0);
    check("p2_last0", data_last, 0);
    in_data = 32'hF1;
    tick();
    in_valid = 1'b0;
    check("p2_data1", data, 32'hF1);
    check("p2_last1", data_last, 1);
    tick();
    check("p2_done", done, 1);
    check("p2_dv_done", data_valid, 0);
    tick();
    check("p2_idle_cmd_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
